// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and helpers for mem_port_arbiter
package mem_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  localparam int MAX_REQ = 8;

  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// rtl/mem_port_arbiter_rr_pick.sv - round-robin picker: first set request at or after ptr, wrapping
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);

  // Walk from the far end back to ptr so the lowest distance from ptr wins last.
  always_comb begin
    int w_k;
    w_k     = 0;
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_k = int'(i_ptr) + i;
      if (w_k >= N) w_k = w_k - N;
      if (i_req[IW'(w_k)]) begin
        o_found = 1'b1;
        o_idx   = IW'(w_k);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin sharing of one native memory port
// Optional MEM_ARB_FAST_REGRANT_EN: re-arbitrate on completion with no idle bubble.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0]  req_wstrb,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [DATA_W-1:0]            req_rdata,
  output logic                         mem_valid,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic [DATA_W/8-1:0]          mem_wstrb,
  input  logic                         mem_ready,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic [$clog2(NUM_REQ)-1:0]   grant_idx
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int SW = DATA_W / 8;

  arb_state_t         r_state;
  logic [IW-1:0]      r_grant;
  logic [IW-1:0]      r_ptr;
  logic [NUM_REQ-1:0] w_mask;
  logic [IW-1:0]      w_pick_ptr;
  logic               w_found;
  logic [IW-1:0]      w_idx;
  logic               w_done;

`ifdef MEM_ARB_FAST_REGRANT_EN
  // While busy the picker looks ahead for the next owner, skipping the current one.
  always_comb begin
    w_mask     = req_valid;
    w_pick_ptr = r_ptr;
    if (r_state == ARB_BUSY) begin
      w_mask     = req_valid & ~(NUM_REQ'(1) << r_grant);
      w_pick_ptr = IW'(rr_next(int'(r_grant), NUM_REQ));
    end
  end
`else
  assign w_mask     = req_valid;
  assign w_pick_ptr = r_ptr;
`endif

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .i_req   (w_mask),
    .i_ptr   (w_pick_ptr),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  // A completion coinciding with reset is swallowed.
  assign w_done    = (r_state == ARB_BUSY) && mem_ready && resetn;
  assign req_ready = w_done ? (NUM_REQ'(1) << r_grant) : '0;
  assign req_rdata = mem_rdata;
  assign mem_valid = (r_state == ARB_BUSY);
  assign mem_addr  = req_addr[r_grant*ADDR_W +: ADDR_W];
  assign mem_wdata = req_wdata[r_grant*DATA_W +: DATA_W];
  assign mem_wstrb = req_wstrb[r_grant*SW +: SW];
  assign grant_idx = r_grant;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_found) begin
            r_grant <= w_idx;
            r_state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (mem_ready) begin
            r_ptr <= IW'(rr_next(int'(r_grant), NUM_REQ));
`ifdef MEM_ARB_FAST_REGRANT_EN
            if (w_found) r_grant <= w_idx;
            else         r_state <= ARB_IDLE;
`else
            r_state <= ARB_IDLE;
`endif
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one native memory port (mem_valid/mem_ready, single-beat) between NUM_REQ requesters, e.g. instruction fetch, load/store unit and a debug/DMA master in the kianv pipeline.
- Arbitration is round-robin. The grant is held for the whole transaction, until mem_ready.
- The memory side is driven from a registered grant. Address, data and strobe are muxed from the granted requester.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width. Strobe width is DATA_W/8.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i in slice i.
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- req_wstrb  in  NUM_REQ*DATA_W/8  packed strobes; all-zero means read.
- req_ready  out  NUM_REQ  one-hot completion pulse to the granted requester.
- req_rdata  out  DATA_W  read data, valid where req_ready is set.
- mem_valid  out  1  request to memory.
- mem_addr  out  ADDR_W  muxed address.
- mem_wdata  out  DATA_W  muxed write data.
- mem_wstrb  out  DATA_W/8  muxed strobe.
- mem_ready  in  1  memory completion (read data valid this cycle).
- mem_rdata  in  DATA_W  memory read data.
- grant_idx  out  $clog2(NUM_REQ)  current owner, for debug/perf counters.

Behaviour:
- Reset (clk edge with resetn=0): state=IDLE, mem_valid=0, req_ready=0, grant_idx=0, rr_ptr=0. Reset takes priority over every other event, including mid-transaction. An outstanding mem_ready in that cycle is dropped and no req_ready is issued.
- States: IDLE, BUSY.
- IDLE:
  - If any req_valid bit is set, pick the first set bit searching from rr_ptr upward, modulo NUM_REQ.
  - Register the pick into grant_idx and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - mem_valid=1. mem_addr, mem_wdata and mem_wstrb are combinational muxes of slice grant_idx.
  - The requester must hold req_valid and its fields stable until req_ready. The arbiter does not check this; the grant is held even if req_valid drops.
- Completion in BUSY with mem_ready=1:
  - req_ready[grant_idx]=1 (combinational, same cycle) and req_rdata=mem_rdata.
  - rr_ptr <= (grant_idx+1) mod NUM_REQ.
  - Next state is IDLE.
- Outputs outside completion: req_ready=0 everywhere except the completion cycle. req_rdata=mem_rdata at all times; only meaningful when req_ready is set.
- Latency: request seen in cycle t gives mem_valid at t+1. Completion takes at least 1 cycle in BUSY. Back-to-back grants have one IDLE bubble.
- No starvation: a continuously asserted requester is granted within NUM_REQ transactions.
- mem_ready while IDLE is ignored.
- All requests low in IDLE: no state change; rr_ptr is unchanged.

Optional Feature:
- Macro: MEM_ARB_FAST_REGRANT_EN.
- With the macro: on completion, arbitrate the same cycle.
  - The request mask excludes the completing requester's current req_valid bit.
  - If another request is pending, load grant_idx and stay in BUSY, so mem_valid stays 1 with no bubble.
  - If none is pending, go to IDLE.
  - The completing requester can win again on the next arbitration.
- Without the macro: always return to IDLE as specified above.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_BUSY};
  - MAX_REQ=8 constant;
  - function rr_next(ptr, n).
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: req mask and ptr.
  - Outputs: found and idx.
  - Used by the IDLE arbitration and by the fast-regrant path.

Test Plan:
- Single read: req_valid=01, addr 0x100, wstrb 0; memory answers mem_ready after 2 BUSY cycles with 0xDEADBEEF -> mem_valid rises 1 cycle after the request; req_ready=01 with req_rdata=0xDEADBEEF; mem_valid drops the next cycle.
- Contention: req_valid=11 held over 4 transactions, memory ready immediately -> grant order 0,1,0,1; rr_ptr toggles.
- Write mux: requester 1 writes addr 0x2000, data 0x12345678, wstrb 0xF while requester 0 is idle -> the mem_* fields match exactly; req_ready[0] never asserts.
- Reset mid-transaction: resetn low while BUSY in the same cycle as mem_ready=1 -> no req_ready; next cycle mem_valid=0, grant_idx=0, rr_ptr=0.
- Starvation (NUM_REQ=4): all 4 requesters held high -> each granted exactly once per 4 completions.
- MEM_ARB_FAST_REGRANT_EN defined, req_valid=11 -> mem_valid stays high continuously across the completion of requester 0, and grant_idx switches to 1 the cycle after completion.
